// File: rtl/dbg_loader_pkg.sv
// Shared state encoding, protocol byte values and helpers for the debug loader.
// Defining DBG_LOADER_ACK_EN adds the ACK state (acknowledge byte after each write).
package dbg_loader_pkg;

  localparam logic [7:0] CmdWrite   = 8'h57;
  localparam logic [7:0] CmdRelease = 8'h52;
  localparam logic [7:0] CmdHold    = 8'h48;
  localparam logic [7:0] AckByte    = 8'h06;

`ifdef DBG_LOADER_ACK_EN
  typedef enum logic [2:0] {StIdle, StAddr, StData, StWrite, StAck} state_e;
`else
  typedef enum logic [1:0] {StIdle, StAddr, StData, StWrite} state_e;
`endif

  // States in which an incoming byte cannot be consumed and is dropped.
  function automatic logic is_busy(state_e s);
`ifdef DBG_LOADER_ACK_EN
    return (s == StWrite) || (s == StAck);
`else
    return (s == StWrite);
`endif
  endfunction

endpackage

// File: rtl/dbg_word_asm.sv
// Little-endian 4-byte assembler: first byte lands in bits 7:0, done pulses with the 4th byte.
// word shows the value including the byte being shifted in this cycle.
module dbg_word_asm (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        done
);

  logic [1:0]  cnt_q;
  logic [31:0] word_q;

  assign word = shift_en ? {byte_in, word_q[31:8]} : word_q;
  assign done = shift_en && (cnt_q == 2'd3);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (shift_en) begin
      cnt_q  <= cnt_q + 2'd1;
      word_q <= word;
    end
  end

endmodule

// File: rtl/dbg_loader.sv
// UART-driven debug loader: 'W' + 4 address + 4 data bytes issues one bus write; 'R'/'H' drive
// the CPU reset. Optional DBG_LOADER_ACK_EN sends 0x06 after each completed write.
module dbg_loader
  import dbg_loader_pkg::*;
#(
  parameter int unsigned WR_CYCLES      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        dbg_mem_op,
  output logic [31:0] dbg_adr,
  output logic [31:0] dbg_do,
  output logic [3:0]  dbg_wren,
  output logic        cpu_n_reset,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        overrun
);

  localparam int unsigned ToW    = $clog2(TIMEOUT_CYCLES);
  localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]     WrLast = 8'(WR_CYCLES - 1);

  state_e         state_q, state_d;
  logic [ToW-1:0] to_cnt_q;
  logic [7:0]     wr_cnt_q;
  logic           in_frame, timeout;
  logic           adr_shift, dat_shift, adr_done, dat_done;
  logic [31:0]    adr_word, dat_word;

  assign in_frame  = (state_q == StAddr) || (state_q == StData);
  // A byte in the timeout cycle wins: the frame continues.
  assign timeout   = in_frame && !rx_valid && (to_cnt_q == ToLast);
  assign adr_shift = (state_q == StAddr) && rx_valid;
  assign dat_shift = (state_q == StData) && rx_valid;

  dbg_word_asm u_adr_asm (
    .clk      (clk),
    .reset    (reset),
    .clear    (state_q == StIdle),
    .shift_en (adr_shift),
    .byte_in  (rx_data),
    .word     (adr_word),
    .done     (adr_done)
  );

  dbg_word_asm u_dat_asm (
    .clk      (clk),
    .reset    (reset),
    .clear    (state_q == StIdle),
    .shift_en (dat_shift),
    .byte_in  (rx_data),
    .word     (dat_word),
    .done     (dat_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (rx_valid && (rx_data == CmdWrite)) state_d = StAddr;
      StAddr:  if (timeout) state_d = StIdle; else if (adr_done) state_d = StData;
      StData:  if (timeout) state_d = StIdle; else if (dat_done) state_d = StWrite;
`ifdef DBG_LOADER_ACK_EN
      StWrite: if (wr_cnt_q == WrLast) state_d = StAck;
      StAck:   if (tx_ready) state_d = StIdle;
`else
      StWrite: if (wr_cnt_q == WrLast) state_d = StIdle;
`endif
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    dbg_mem_op = 1'b0;
    dbg_wren   = 4'h0;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    if (state_q == StWrite) begin
      dbg_mem_op = 1'b1;
      dbg_wren   = 4'hF;
    end
`ifdef DBG_LOADER_ACK_EN
    if (state_q == StAck) begin
      tx_valid = 1'b1;
      tx_data  = AckByte;
    end
`endif
  end

`ifndef DBG_LOADER_ACK_EN
  logic unused_tx_ready;
  assign unused_tx_ready = tx_ready;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      dbg_adr     <= '0;
      dbg_do      <= '0;
      cpu_n_reset <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if ((state_q == StIdle) && rx_valid) begin
        if (rx_data == CmdRelease) begin
          cpu_n_reset <= 1'b1;
        end else if (rx_data == CmdHold) begin
          cpu_n_reset <= 1'b0;
        end
      end
      if (in_frame && !rx_valid && !timeout) begin
        to_cnt_q <= to_cnt_q + ToW'(1);
      end else begin
        to_cnt_q <= '0;
      end
      if ((state_q == StWrite) && (wr_cnt_q != WrLast)) begin
        wr_cnt_q <= wr_cnt_q + 8'd1;
      end else begin
        wr_cnt_q <= '0;
      end
      // Bus-visible address/data change only as WRITE is entered.
      if (dat_done) begin
        dbg_adr <= adr_word;
        dbg_do  <= dat_word;
      end
      if (rx_valid && is_busy(state_q)) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dbg_loader.sv
// Self-checking bench for dbg_loader: directed scenarios plus randomized frames and commands,
// compared against a frame-level model of the loader protocol.
module tb_dbg_loader;

  localparam int unsigned WrCycles = 4;
  localparam int unsigned ToCycles = 50;
`ifdef DBG_LOADER_ACK_EN
  localparam int AckPerFrame = 1;
`else
  localparam int AckPerFrame = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        tx_ready = 1'b1;
  logic        dbg_mem_op;
  logic [31:0] dbg_adr;
  logic [31:0] dbg_do;
  logic [3:0]  dbg_wren;
  logic        cpu_n_reset;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        overrun;

  dbg_loader #(
    .WR_CYCLES      (WrCycles),
    .TIMEOUT_CYCLES (ToCycles)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .dbg_mem_op  (dbg_mem_op),
    .dbg_adr     (dbg_adr),
    .dbg_do      (dbg_do),
    .dbg_wren    (dbg_wren),
    .cpu_n_reset (cpu_n_reset),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Monitor: accumulates bus activity, sampled mid-cycle.
  int          op_cycles = 0;
  int          cpu_hi_ops = 0;
  int          wren_err = 0;
  int          txv_cycles = 0;
  int          acks = 0;
  logic [31:0] mon_adr = '0;
  logic [31:0] mon_do = '0;

  always @(negedge clk) begin
    if (dbg_mem_op) begin
      op_cycles = op_cycles + 1;
      mon_adr   = dbg_adr;
      mon_do    = dbg_do;
      if (dbg_wren !== 4'hF) wren_err = wren_err + 1;
      if (cpu_n_reset) cpu_hi_ops = cpu_hi_ops + 1;
    end else if (dbg_wren !== 4'h0) begin
      wren_err = wren_err + 1;
    end
    if (tx_valid) begin
      txv_cycles = txv_cycles + 1;
      if (tx_ready && (tx_data == 8'h06)) acks = acks + 1;
    end
  end

  // Model state: last completed write, CPU reset level, sticky overrun.
  logic [31:0] exp_adr = '0;
  logic [31:0] exp_do = '0;
  logic        exp_cpu = 1'b0;
  logic        exp_ovr = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sends 'W' then adr/dat little-endian; first_gap idle cycles before the first address byte.
  task automatic do_frame(input logic [31:0] adr, input logic [31:0] dat, input int gap_max,
                          input int first_gap, input bit inject);
    logic [63:0] frame;
    int          ops0, ack0;
    ops0  = op_cycles;
    ack0  = acks;
    frame = {dat, adr};
    send(8'h57);
    for (int i = 0; i < 8; i++) begin
      idle((i == 0) ? first_gap : int'($urandom_range(gap_max, 0)));
      send(frame[8*i +: 8]);
      if (i == 4) begin
        check("adr_held_mid_frame", dbg_adr, exp_adr);
        check("do_held_mid_frame", dbg_do, exp_do);
      end
    end
    check("mem_op_after_last_byte", {31'd0, dbg_mem_op}, 32'd1);
    check("adr_on_write", dbg_adr, adr);
    check("do_on_write", dbg_do, dat);
    if (inject) begin
      send(8'h57);
      exp_ovr = 1'b1;
      check("overrun_set", {31'd0, overrun}, 32'd1);
    end
    idle(WrCycles + 3);
    exp_adr = adr;
    exp_do  = dat;
    check("mem_op_cycles", op_cycles - ops0, WrCycles);
    check("write_adr", mon_adr, adr);
    check("write_do", mon_do, dat);
    check("adr_hold_after", dbg_adr, adr);
    check("ack_count", acks - ack0, AckPerFrame);
    check("overrun", {31'd0, overrun}, {31'd0, exp_ovr});
    check("cpu_n_reset", {31'd0, cpu_n_reset}, {31'd0, exp_cpu});
  endtask

  initial begin
    int          ops0, ack0, txv0, kind;
    logic [7:0]  b;
    logic [63:0] frame;

    // Reset values.
    idle(3);
    check("rst_cpu_n_reset", {31'd0, cpu_n_reset}, 32'd0);
    check("rst_mem_op", {31'd0, dbg_mem_op}, 32'd0);
    check("rst_wren", {28'd0, dbg_wren}, 32'd0);
    check("rst_adr", dbg_adr, 32'd0);
    check("rst_do", dbg_do, 32'd0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    reset = 1'b0;
    idle(2);

    // Reference frame 57 00 00 02 00 37 05 00 00.
    do_frame(32'h0002_0000, 32'h0000_0537, 0, 0, 1'b0);

    // Hold, write, release: CPU stays in reset through the write.
    send(8'h48);
    check("hold_cpu", {31'd0, cpu_n_reset}, 32'd0);
    ops0 = cpu_hi_ops;
    do_frame(32'h0001_0000, 32'h0000_00BB, 2, 0, 1'b0);
    check("cpu_low_during_write", cpu_hi_ops - ops0, 32'd0);
    send(8'h52);
    exp_cpu = 1'b1;
    check("release_cpu", {31'd0, cpu_n_reset}, 32'd1);

    // Partial frame then full timeout silence: aborted, no write.
    ops0 = op_cycles;
    send(8'h57);
    send(8'h00);
    send(8'h00);
    idle(ToCycles);
    idle(WrCycles + 2);
    check("no_write_after_timeout", op_cycles - ops0, 32'd0);
    check("adr_after_timeout", dbg_adr, exp_adr);
    do_frame(32'h1122_3344, 32'hAABB_CCDD, 1, 0, 1'b0);

    // Byte arriving in the timeout cycle is accepted.
    do_frame(32'h8000_0004, 32'hDEAD_BEEF, 0, ToCycles - 1, 1'b0);

    // Randomized mix of frames, hold/release and ignored bytes.
    for (int n = 0; n < 24; n++) begin
      kind = int'($urandom_range(3, 0));
      if (kind == 0) begin
        do_frame($urandom, $urandom, 3, int'($urandom_range(3, 0)), 1'b0);
      end else if (kind == 1) begin
        send(8'h48);
        exp_cpu = 1'b0;
        check("rnd_hold", {31'd0, cpu_n_reset}, 32'd0);
      end else if (kind == 2) begin
        send(8'h52);
        exp_cpu = 1'b1;
        check("rnd_release", {31'd0, cpu_n_reset}, 32'd1);
      end else begin
        do b = 8'($urandom); while (b == 8'h57 || b == 8'h52 || b == 8'h48);
        ops0 = op_cycles;
        send(b);
        idle(WrCycles + 2);
        check("junk_ignored_op", op_cycles - ops0, 32'd0);
        check("junk_ignored_cpu", {31'd0, cpu_n_reset}, {31'd0, exp_cpu});
      end
    end

    // Byte during WRITE: dropped, overrun sticks, write unaffected.
    do_frame(32'h0000_1000, 32'h1234_5678, 1, 0, 1'b1);
    do_frame(32'h0000_2000, 32'h8765_4321, 1, 0, 1'b0);

`ifdef DBG_LOADER_ACK_EN
    // Stalled acknowledge: tx_valid held, byte during ACK sets overrun.
    tx_ready = 1'b0;
    frame = {32'h0000_00AA, 32'h0000_3000};
    send(8'h57);
    for (int i = 0; i < 8; i++) send(frame[8*i +: 8]);
    idle(WrCycles);
    txv0 = txv_cycles;
    idle(10);
    check("ack_stall_valid_cycles", txv_cycles - txv0, 32'd10);
    check("ack_stall_data", {24'd0, tx_data}, 32'h06);
    send(8'h57);
    check("ack_overrun", {31'd0, overrun}, 32'd1);
    tx_ready = 1'b1;
    tick();
    check("ack_valid_dropped", {31'd0, tx_valid}, 32'd0);
    exp_adr = 32'h0000_3000;
    exp_do  = 32'h0000_00AA;
`endif

    // Reset in the second WRITE cycle.
    send(8'h52);
    exp_cpu = 1'b1;
    ops0  = op_cycles;
    ack0  = acks;
    frame = {32'h5555_AAAA, 32'h0000_4000};
    send(8'h57);
    for (int i = 0; i < 8; i++) send(frame[8*i +: 8]);
    tick();
    reset = 1'b1;
    tick();
    check("rst_write_mem_op", {31'd0, dbg_mem_op}, 32'd0);
    check("rst_write_cpu", {31'd0, cpu_n_reset}, 32'd0);
    check("rst_write_overrun", {31'd0, overrun}, 32'd0);
    reset   = 1'b0;
    exp_cpu = 1'b0;
    exp_ovr = 1'b0;
    exp_adr = '0;
    exp_do  = '0;
    idle(WrCycles + 3);
    check("rst_write_op_cycles", op_cycles - ops0, 32'd2);
    check("rst_write_no_ack", acks - ack0, 32'd0);
    check("rst_write_adr", dbg_adr, 32'd0);

    do_frame(32'hCAFE_0000, 32'h0BAD_F00D, 2, 0, 1'b0);

    check("wren_consistency", wren_err, 32'd0);
`ifndef DBG_LOADER_ACK_EN
    check("tx_valid_never", txv_cycles, 32'd0);
    check("tx_data_const", {24'd0, tx_data}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dbg_loader.md
DBG_LOADER -- requirements
Module: dbg_loader

Interface
Parameters:
REQ-001 SHALL have parameter WR_CYCLES, default 4: number of cycles dbg_mem_op is held per write, legal range 1..255.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000: idle cycles between frame bytes before the frame is aborted, minimum 2.

Ports:
REQ-003 SHALL have port clk, input, 1: the single clock.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port rx_data, input, 8: received UART byte.
REQ-006 SHALL have port rx_valid, input, 1: one-cycle strobe qualifying rx_data.
REQ-007 SHALL have port dbg_mem_op, output, 1: debug memory-write request to the SoC bus.
REQ-008 SHALL have port dbg_adr, output, 32: debug write address.
REQ-009 SHALL have port dbg_do, output, 32: debug write data.
REQ-010 SHALL have port dbg_wren, output, 4: debug byte-lane write enables.
REQ-011 SHALL have port cpu_n_reset, output, 1: CPU reset, active low.
REQ-012 SHALL have port tx_data, output, 8: acknowledge byte.
REQ-013 SHALL have port tx_valid, output, 1: acknowledge request.
REQ-014 SHALL have port tx_ready, input, 1: the UART transmitter accepts tx_data.
REQ-015 SHALL have port overrun, output, 1: sticky flag, set when a byte is dropped.

Function
REQ-016 Command bytes SHALL be: 0x57 'W' (write frame), 0x52 'R' (release CPU), 0x48 'H' (hold CPU); any other byte in IDLE SHALL be ignored.
REQ-017 States SHALL be IDLE, ADDR, DATA, WRITE, ACK.
REQ-018 In IDLE, 'W' -> ADDR; 'R' -> cpu_n_reset=1 on the next cycle; 'H' -> cpu_n_reset=0 on the next cycle; state stays IDLE for 'R'/'H'.
REQ-019 ADDR SHALL accept 4 bytes, little-endian (first byte -> bits 7:0), then go to DATA.
REQ-020 DATA SHALL accept 4 bytes, little-endian, then go to WRITE.
REQ-021 Address and data SHALL be assembled in shadow registers; dbg_adr and dbg_do SHALL change only on entry to WRITE.
REQ-022 WRITE SHALL assert dbg_mem_op=1 and dbg_wren=4'hF for exactly WR_CYCLES cycles, starting the cycle after the last data byte; then go to ACK (ACK_EN) or IDLE.
REQ-023 Outside WRITE, dbg_mem_op=0 and dbg_wren=0; dbg_adr and dbg_do SHALL hold their last values.
REQ-024 A write SHALL be executed regardless of cpu_n_reset; the host is responsible for holding the CPU ('H') beforehand.
REQ-025 The timeout counter SHALL clear on every accepted byte in ADDR/DATA and increment otherwise; on reaching TIMEOUT_CYCLES-1 in ADDR/DATA the state SHALL return to IDLE, the partial frame SHALL be discarded and no write SHALL occur.
REQ-026 An rx_valid in WRITE or ACK SHALL drop the byte and set overrun=1 (sticky until reset).
REQ-027 A byte arriving in the same cycle as the timeout SHALL be treated as accepted; the timeout SHALL NOT fire.

Reset
REQ-028 While reset=1, on each clk edge: state=IDLE, cpu_n_reset=0, dbg_mem_op=0, dbg_wren=0, dbg_adr=0, dbg_do=0, tx_valid=0, tx_data=0, overrun=0, counters=0.
REQ-029 A reset during WRITE SHALL drop dbg_mem_op on the next edge; the interrupted write is undefined at memory and SHALL NOT be acked.

Configuration
REQ-030 With DBG_LOADER_ACK_EN defined, ACK SHALL drive tx_data=0x06 and tx_valid=1 until a cycle with tx_ready=1, then go to IDLE; tx_valid SHALL drop the cycle after.
REQ-031 Without DBG_LOADER_ACK_EN, the ACK state SHALL be absent, tx_valid SHALL be constant 0 and tx_data constant 0; tx_ready SHALL be unused.

Structure
REQ-032 Package dbg_loader_pkg SHALL hold the state enum, the command constants (0x57/0x52/0x48) and the ACK byte 0x06.
REQ-033 One sub-module, dbg_word_asm (a 4-byte little-endian shift/assemble register with byte counter and done flag), SHALL be instantiated twice (address, data).

Verification
REQ-034 Bytes 57 00 00 02 00 37 05 00 00 -> one write: dbg_adr=0x00020000, dbg_do=0x00000537, dbg_mem_op high 4 cycles; with ACK_EN, tx 0x06.
REQ-035 'H', a write frame to 0x10000 with data 0xBB, then 'R' -> cpu_n_reset stays 0 through the write and rises 1 cycle after 'R'.
REQ-036 57 00 00 and then a silence of TIMEOUT_CYCLES -> no dbg_mem_op; the next full frame writes correctly.
REQ-037 rx_valid during WRITE -> overrun=1 and the write values are unchanged; overrun stays 1 until reset.
REQ-038 reset asserted in the 2nd WRITE cycle -> dbg_mem_op=0 and cpu_n_reset=0 next cycle, no ack.
REQ-039 With ACK_EN and tx_ready held 0 for 10 cycles -> tx_valid stays 1 with tx_data=0x06, and the next 'W' sets overrun.
